mem_test_initiator: RTL

Initiator (master) for the single-port memory valid/ready request interface. On a start pulse it writes a seed-derived pattern to every address, reads every address back and compares each word. It reports pass/fail, an error count, the first failing address and a response timeout. It is used for memory bring-up and self-test in front of the memory responder.

---
 rtl/mem_test_pkg.sv | 30 +++
 rtl/mem_rsp_timer.sv | 38 +++
 rtl/mem_test_initiator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared definitions for the memory test initiator.
//   - state_e      : initiator FSM states
//   - Def*         : default WIDTH / DEPTH / TIMEOUT values
//   - pattern_word : test word for a (seed, addr, invert) triple; callers truncate to WIDTH
// Ports: none (package).
package mem_test_pkg;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefDepth   = 16;
  localparam int unsigned DefTimeout = 15;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrWait,
    StRdIssue,
    StRdWait,
    StDone
  } state_e;

  // Computed at 64 bits so a single function serves every WIDTH up to 64. The address is
  // zero-extended here; the caller's cast to WIDTH performs any truncation.
  function automatic logic [63:0] pattern_word(logic [63:0] seed, logic [63:0] addr,
                                               logic invert);
    logic [63:0] w_word;
    w_word = seed ^ addr;
    return invert ? ~w_word : w_word;
  endfunction

endpackage

// File: rtl/mem_rsp_timer.sv
// mem_rsp_timer: counts consecutive response-wait cycles for the memory test initiator.
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clr_i     : restart the count (held while a request is being issued)
//   en_i      : a wait cycle without acknowledge is in progress
//   expired_o : this enabled cycle is the TIMEOUT-th consecutive wait cycle
module mem_rsp_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_at_limit;

  // The count holds the number of wait cycles already elapsed, so the cycle that sees
  // TIMEOUT-1 is itself the TIMEOUT-th one.
  assign w_at_limit = (r_cnt == CntW'(TIMEOUT - 1));
  assign expired_o  = en_i && w_at_limit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_test_initiator.sv
// mem_test_initiator: memory self-test master on the valid/ready single-port request bus.
// On an accepted start it writes pattern (seed ^ addr) to addresses 0..DEPTH-1, reads them
// back and compares. Each request is a one-cycle valid_o pulse followed by a wait for ready_i.
// Optional build macro MEM_TEST_INVERT_PASS_EN adds a second write/read pass using the
// inverted pattern; errors accumulate across both passes. WIDTH must not exceed 64.
// Ports:
//   clk_i, rst_ni           : clock (rising edge), asynchronous active-low reset
//   start_i, seed_i         : start pulse (honoured only when idle/done) and pattern seed
//   valid_o, rd_wr_o        : request valid, 1 = write / 0 = read
//   addr_o, wdata_o         : request address and write data (registered, 0 when idle/done)
//   ready_i, rdata_i        : responder acknowledge; read data valid alongside ready_i
//   busy_o, done_o, pass_o  : test running, test finished (level), finished cleanly
//   timeout_o               : test aborted because no acknowledge arrived within TIMEOUT
//   err_cnt_o               : mismatching reads, saturating at DEPTH
//   first_err_addr_o        : address of the first mismatch, 0 if none
module mem_test_initiator
  import mem_test_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic                  valid_o,
  output logic                  rd_wr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam int unsigned            ErrW     = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0]  LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ErrW-1:0]        ErrMax   = ErrW'(DEPTH);

  state_e                r_state;
  logic [WIDTH-1:0]      r_seed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inv;
  logic                  r_valid;
  logic                  r_rd_wr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_timeout;
  logic [ErrW-1:0]       r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err;

  logic                  w_is_issue;
  logic                  w_is_wait;
  logic                  w_timer_en;
  logic                  w_expired;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [WIDTH-1:0]      w_expected;
  logic [WIDTH-1:0]      w_wdata_next;
  logic                  w_mismatch;

  assign w_is_issue   = (r_state == StWrIssue) || (r_state == StRdIssue);
  assign w_is_wait    = (r_state == StWrWait) || (r_state == StRdWait);
  assign w_timer_en   = w_is_wait && !ready_i;
  assign w_addr_inc   = r_addr + 1'b1;
  assign w_expected   = WIDTH'(pattern_word(64'(r_seed), 64'(r_addr), r_inv));
  assign w_wdata_next = WIDTH'(pattern_word(64'(r_seed), 64'(w_addr_inc), r_inv));
  assign w_mismatch   = (rdata_i != w_expected);

  mem_rsp_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (w_is_issue),
    .en_i     (w_timer_en),
    .expired_o(w_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_seed      <= '0;
      r_addr      <= '0;
      r_inv       <= 1'b0;
      r_valid     <= 1'b0;
      r_rd_wr     <= 1'b0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      // valid_o is a single-cycle pulse; only an issuing state raises it.
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start_i) begin
            r_seed      <= seed_i;
            r_addr      <= '0;
            r_inv       <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_rd_wr     <= 1'b1;
            r_wdata     <= seed_i;  // seed ^ 0
            r_state     <= StWrIssue;
          end
        end
        StWrIssue, StRdIssue: begin
          // A ready_i still high from the previous acknowledge must not be taken as the
          // answer to the new request, so hold off issuing until it drops.
          if (!ready_i) begin
            r_valid <= 1'b1;
            r_state <= (r_state == StWrIssue) ? StWrWait : StRdWait;
          end
        end
        StWrWait, StRdWait: begin
          if (ready_i) begin
            if ((r_state == StRdWait) && w_mismatch) begin
              if (r_err_cnt != ErrMax) r_err_cnt <= r_err_cnt + 1'b1;
              if (r_err_cnt == '0) r_first_err <= r_addr;
            end
            if (r_addr != LastAddr) begin
              r_addr  <= w_addr_inc;
              r_wdata <= r_rd_wr ? w_wdata_next : '0;
              r_state <= (r_state == StWrWait) ? StWrIssue : StRdIssue;
            end else if (r_state == StWrWait) begin
              r_addr  <= '0;
              r_rd_wr <= 1'b0;
              r_wdata <= '0;
              r_state <= StRdIssue;
`ifdef MEM_TEST_INVERT_PASS_EN
            end else if (!r_inv) begin
              r_inv   <= 1'b1;
              r_addr  <= '0;
              r_rd_wr <= 1'b1;
              r_wdata <= WIDTH'(pattern_word(64'(r_seed), 64'd0, 1'b1));
              r_state <= StWrIssue;
`endif
            end else begin
              r_addr  <= '0;
              r_rd_wr <= 1'b0;
              r_wdata <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_addr    <= '0;
            r_rd_wr   <= 1'b0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign valid_o          = r_valid;
  assign rd_wr_o          = r_rd_wr;
  assign addr_o           = r_addr;
  assign wdata_o          = r_wdata;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign timeout_o        = r_timeout;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err;
  assign pass_o           = r_done && (r_err_cnt == '0) && !r_timeout;

endmodule
